// File: rtl/friscv_gpio_ctrl.sv
// Banked GPIO controller on the native IO bus: per-pin output/OE, atomic set/clear,
// synchronised inputs and rise/fall edge interrupts with W1C status.
module friscv_gpio_ctrl #(
  parameter int ADDRW       = 15,
  parameter int XLEN        = 32,
  parameter int NB_BANK     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    mst_en,
  input  logic                    mst_wr,
  input  logic [ADDRW-1:0]        mst_addr,
  input  logic [XLEN-1:0]         mst_wdata,
  input  logic [XLEN/8-1:0]       mst_strb,
  output logic [XLEN-1:0]         mst_rdata,
  output logic                    mst_ready,
  input  logic [NB_BANK*XLEN-1:0] gpio_in,
  output logic [NB_BANK*XLEN-1:0] gpio_out,
  output logic [NB_BANK*XLEN-1:0] gpio_oe,
  output logic                    irq
);

  localparam int PW    = NB_BANK * XLEN;
  localparam int BANKW = ADDRW - 3;

  typedef enum logic {IDLE, ACK} state_t;

  state_t               state;
  state_t               state_next;
  logic                 exec;
  logic [BANKW-1:0]     bank_sel;
  logic [2:0]           reg_sel;
  logic [XLEN-1:0]      wmask;
  logic [XLEN-1:0]      rd_mux;
  logic [PW-1:0]        rd_flat;
  logic [NB_BANK-1:0]   stat_any;
  logic [PW-1:0]        sync_q [SYNC_STAGES];
  logic [PW-1:0]        prev_q;
  logic [PW-1:0]        sync_out;

  assign bank_sel = mst_addr[ADDRW-1:3];
  assign reg_sel  = mst_addr[2:0];
  assign sync_out = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < XLEN/8; i++) begin : g_mask
    assign wmask[i*8 +: 8] = {8{mst_strb[i]}};
  end

  always_ff @(posedge aclk) begin
    if (srst) state <= IDLE;
    else      state <= state_next;
  end

  // An access executes only from IDLE; ACK swallows mst_en for one cycle.
  always_comb begin
    state_next = state;
    exec       = 1'b0;
    case (state)
      IDLE: begin
        if (mst_en) begin
          exec       = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
    end
  end

  for (genvar b = 0; b < NB_BANK; b++) begin : g_bank
    logic [XLEN-1:0] out_q;
    logic [XLEN-1:0] oe_q;
    logic [XLEN-1:0] rise_q;
    logic [XLEN-1:0] fall_q;
    logic [XLEN-1:0] stat_q;
    logic [XLEN-1:0] pin;
    logic [XLEN-1:0] pin_prev;
    logic [XLEN-1:0] events;
    logic [XLEN-1:0] clr_mask;
    logic [XLEN-1:0] rd_word;
    logic            wr_hit;

    assign pin      = sync_out[b*XLEN +: XLEN];
    assign pin_prev = prev_q[b*XLEN +: XLEN];
    assign events   = (pin & ~pin_prev & rise_q) | (~pin & pin_prev & fall_q);
    assign wr_hit   = exec && mst_wr && (bank_sel == BANKW'(b));
    assign clr_mask = (wr_hit && reg_sel == 3'd5) ? (mst_wdata & wmask) : '0;

    always_ff @(posedge aclk) begin
      if (srst) begin
        out_q  <= '0;
        oe_q   <= '0;
        rise_q <= '0;
        fall_q <= '0;
        stat_q <= '0;
      end else begin
        if (wr_hit) begin
          case (reg_sel)
            3'd0:    out_q  <= (out_q & ~wmask) | (mst_wdata & wmask);
            3'd2:    oe_q   <= (oe_q & ~wmask) | (mst_wdata & wmask);
            3'd3:    rise_q <= (rise_q & ~wmask) | (mst_wdata & wmask);
            3'd4:    fall_q <= (fall_q & ~wmask) | (mst_wdata & wmask);
            3'd6:    out_q  <= out_q | (mst_wdata & wmask);
            3'd7:    out_q  <= out_q & ~(mst_wdata & wmask);
            default: ;
          endcase
        end
        // A new edge overrides a W1C landing on the same bit.
        stat_q <= (stat_q & ~clr_mask) | events;
      end
    end

    always_comb begin
      rd_word = '0;
      case (reg_sel)
        3'd0:    rd_word = out_q;
        3'd1:    rd_word = pin;
        3'd2:    rd_word = oe_q;
        3'd3:    rd_word = rise_q;
        3'd4:    rd_word = fall_q;
        3'd5:    rd_word = stat_q;
        default: rd_word = '0;
      endcase
    end

    assign rd_flat[b*XLEN +: XLEN]  = rd_word;
    assign gpio_out[b*XLEN +: XLEN] = out_q;
    assign gpio_oe[b*XLEN +: XLEN]  = oe_q;
    assign stat_any[b]              = |stat_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      if (bank_sel == BANKW'(b)) rd_mux = rd_flat[b*XLEN +: XLEN];
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      mst_ready <= 1'b0;
      mst_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      mst_ready <= exec;
      mst_rdata <= (exec && !mst_wr) ? rd_mux : '0;
      irq       <= |stat_any;
    end
  end

endmodule

// File: tb/tb_friscv_gpio_ctrl.sv
// Directed self-checking bench for friscv_gpio_ctrl with default parameters
// (2 banks of 32 pins, 2-stage synchroniser).
module tb_friscv_gpio_ctrl;

  logic        aclk;
  logic        srst;
  logic        mst_en;
  logic        mst_wr;
  logic [14:0] mst_addr;
  logic [31:0] mst_wdata;
  logic [3:0]  mst_strb;
  logic [31:0] mst_rdata;
  logic        mst_ready;
  logic [63:0] gpio_in;
  logic [63:0] gpio_out;
  logic [63:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  friscv_gpio_ctrl #(
    .ADDRW(15), .XLEN(32), .NB_BANK(2), .SYNC_STAGES(2)
  ) dut (
    .aclk(aclk), .srst(srst),
    .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_strb(mst_strb),
    .mst_rdata(mst_rdata), .mst_ready(mst_ready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One bus access; returns read data and the number of edges until ready.
  task automatic applyStimulus(input logic wr, input logic [14:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, output logic [31:0] rdata, output int cycles);
    int n;
    mst_en    = 1'b1;
    mst_wr    = wr;
    mst_addr  = addr;
    mst_wdata = wdata;
    mst_strb  = strb;
    rdata     = '0;
    cycles    = 0;
    n         = 0;
    while (cycles == 0 && n < 4) begin
      @(posedge aclk);
      #1;
      n++;
      if (mst_ready) begin
        cycles = n;
        rdata  = mst_rdata;
      end
    end
    mst_en = 1'b0;
    mst_wr = 1'b0;
    if (cycles == 0) checkOutput("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic writeReg(input logic [14:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] rd;
    int cyc;
    applyStimulus(1'b1, addr, wdata, strb, rd, cyc);
  endtask

  task automatic readReg(input logic [14:0] addr, output logic [31:0] rdata);
    int cyc;
    applyStimulus(1'b0, addr, 32'h0, 4'h0, rdata, cyc);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    srst = 1'b1; mst_en = 1'b0; mst_wr = 1'b0; mst_addr = '0;
    mst_wdata = '0; mst_strb = '0; gpio_in = '0;
    waitCycles(3);
    checkOutput("reset_gpio_out", gpio_out, 64'h0);
    checkOutput("reset_gpio_oe", gpio_oe, 64'h0);
    checkOutput("reset_irq", {63'h0, irq}, 64'h0);
    checkOutput("reset_ready", {63'h0, mst_ready}, 64'h0);
    srst = 1'b0;
    waitCycles(1);

    writeReg(15'h0, 32'h09876543, 4'hF);
    checkOutput("out_bank0", gpio_out[31:0], 64'h09876543);
    writeReg(15'h2, 32'hFFFFFFFF, 4'hF);
    checkOutput("oe_bank0", gpio_oe[31:0], 64'hFFFFFFFF);
    writeReg(15'h8, 32'hAABBCCDD, 4'h2);
    checkOutput("out_bank1_strb", gpio_out[63:32], 64'h0000CC00);
    readReg(15'h0, rd);
    checkOutput("out_bank0_rd", rd, 64'h09876543);

    gpio_in = {32'h5A5A5A5A, 32'hA5A5A5A5};
    waitCycles(2);
    readReg(15'h1, rd);
    checkOutput("in_bank0", rd, 64'hA5A5A5A5);
    readReg(15'h9, rd);
    checkOutput("in_bank1", rd, 64'h5A5A5A5A);
    writeReg(15'h1, 32'h0, 4'hF);
    readReg(15'h1, rd);
    checkOutput("in_write_ignored", rd, 64'hA5A5A5A5);

    // Edges seen while disabled must not be remembered.
    gpio_in[31:0] = 32'h2;
    waitCycles(4);
    writeReg(15'h3, 32'h1, 4'hF);
    writeReg(15'h4, 32'h2, 4'hF);
    readReg(15'h5, rd);
    checkOutput("status_disabled_edges", rd, 64'h0);
    waitCycles(1);
    gpio_in[31:0] = 32'h1;
    waitCycles(3);
    checkOutput("irq_edge_s_plus_1", {63'h0, irq}, 64'h0);
    waitCycles(1);
    checkOutput("irq_edge_s_plus_2", {63'h0, irq}, 64'h1);
    readReg(15'h5, rd);
    checkOutput("status_both", rd, 64'h3);

    writeReg(15'h5, 32'h1, 4'hF);
    readReg(15'h5, rd);
    checkOutput("status_after_w1c0", rd, 64'h2);
    checkOutput("irq_still_set", {63'h0, irq}, 64'h1);

    gpio_in[1] = 1'b1;
    waitCycles(4);
    gpio_in[1] = 1'b0;
    waitCycles(2);
    writeReg(15'h5, 32'h2, 4'hF);
    readReg(15'h5, rd);
    checkOutput("status_set_wins", rd, 64'h2);

    writeReg(15'h5, 32'h2, 4'hF);
    checkOutput("irq_lag_after_w1c", {63'h0, irq}, 64'h1);
    waitCycles(1);
    checkOutput("irq_drop", {63'h0, irq}, 64'h0);
    readReg(15'h5, rd);
    checkOutput("status_cleared", rd, 64'h0);

    applyStimulus(1'b1, 15'h1000, 32'hFFFFFFFF, 4'hF, rd, cyc);
    checkOutput("oor_wr_ready_cycles", (cyc >= 1 && cyc <= 2) ? 64'd1 : 64'd0, 64'd1);
    checkOutput("oor_out_unchanged", gpio_out, 64'h0000CC00_09876543);
    checkOutput("oor_oe_unchanged", gpio_oe, 64'h00000000_FFFFFFFF);
    waitCycles(1);
    applyStimulus(1'b0, 15'h1000, 32'h0, 4'h0, rd, cyc);
    checkOutput("oor_rd_ready_cycles", (cyc >= 1 && cyc <= 2) ? 64'd1 : 64'd0, 64'd1);
    checkOutput("oor_rdata", rd, 64'h0);
    readReg(15'h3, rd);
    checkOutput("oor_rise_unchanged", rd, 64'h1);

    writeReg(15'h0, 32'h000000F0, 4'hF);
    writeReg(15'h6, 32'h0000000F, 4'hF);
    writeReg(15'h7, 32'h00000081, 4'hF);
    readReg(15'h0, rd);
    checkOutput("set_clr", rd, 64'h7E);
    readReg(15'h6, rd);
    checkOutput("rd_set_zero", rd, 64'h0);
    readReg(15'h7, rd);
    checkOutput("rd_clr_zero", rd, 64'h0);
    writeReg(15'h6, 32'hFFFF0000, 4'h4);
    checkOutput("set_strb", gpio_out[31:0], 64'h00FF007E);
    writeReg(15'h7, 32'h000000FF, 4'h2);
    checkOutput("clr_strb_masked", gpio_out[31:0], 64'h00FF007E);

    waitCycles(1);
    mst_en = 1'b1; mst_wr = 1'b1; mst_addr = 15'h0;
    mst_wdata = 32'h12345678; mst_strb = 4'hF;
    srst = 1'b1;
    waitCycles(1);
    checkOutput("rst_mid_ready", {63'h0, mst_ready}, 64'h0);
    checkOutput("rst_mid_out", gpio_out, 64'h0);
    checkOutput("rst_mid_oe", gpio_oe, 64'h0);
    checkOutput("rst_mid_irq", {63'h0, irq}, 64'h0);
    mst_en = 1'b0; mst_wr = 1'b0;
    waitCycles(1);
    srst = 1'b0;
    waitCycles(1);
    readReg(15'h3, rd);
    checkOutput("rst_rise_en_cleared", rd, 64'h0);
    writeReg(15'h0, 32'h12345678, 4'hF);
    checkOutput("reissue_out", gpio_out[31:0], 64'h12345678);
    waitCycles(5);
    checkOutput("post_rst_rise_not_latched", {63'h0, irq}, 64'h0);
    readReg(15'h5, rd);
    checkOutput("post_rst_status", rd, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/friscv_gpio_ctrl.md
# friscv_gpio_ctrl

Parametrised GPIO controller. It replaces the single fixed-width GPIO slave on the IO bus with NB_BANK banks of XLEN pins each. Each pin has output-enable control, atomic set/clear, input synchronisation and per-pin rising/falling edge interrupts. It sits behind the IO interconnect on the same native master bus (en/wr/addr/wdata/strb/rdata/ready), and its irq output feeds the core's external interrupt line.

## Interface
- ADDRW, 15, bus address width (word address)
- XLEN, 32, data width and pins per bank
- NB_BANK, 2, number of pin banks (1..8)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- aclk  in  1  clock
- srst  in  1  reset, synchronous, active-high; one clock domain, no other reset
- mst_en  in  1  access request, held until mst_ready
- mst_wr  in  1  1 = write, 0 = read
- mst_addr  in  ADDRW  word address, local to this slave
- mst_wdata  in  XLEN  write data
- mst_strb  in  XLEN/8  byte enables for writes
- mst_rdata  out  XLEN  read data, valid while mst_ready=1
- mst_ready  out  1  access completion, one-cycle pulse
- gpio_in  in  NB_BANK*XLEN  asynchronous pin inputs, bank b at bits [b*XLEN +: XLEN]
- gpio_out  out  NB_BANK*XLEN  pin output values
- gpio_oe  out  NB_BANK*XLEN  pin output enables (1 = drive)
- irq  out  1  level interrupt, OR of all pending status bits

## Operation
- Address decode: bank = addr[ADDRW-1:3], reg = addr[2:0]. Stride is 8 words per bank.
- Registers per bank:
  - 0 OUT (RW)
  - 1 IN (RO, synchronised pins)
  - 2 OE (RW)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 STATUS (RW1C)
  - 6 SET (WO, OUT |= wdata)
  - 7 CLR (WO, OUT &= ~wdata)
- Writes honour mst_strb per byte, including SET/CLR/STATUS: masked bytes are unaffected.
- Reads of SET/CLR return 0. Writes to IN are ignored.
- Bank index >= NB_BANK: the access still completes with ready, rdata = 0, and no state changes. The bus must never hang.
- Input path: each pin passes through a SYNC_STAGES flop chain, then a prev register. IN returns the chain output.
- Edge detect, per pin:
  - rise = sync & ~prev; fall = ~sync & prev.
  - STATUS bit sets when (rise & RISE_EN) | (fall & FALL_EN).
  - Enables are sampled on the same edge as the detection. Edges that occur while disabled are not remembered.
- Simultaneous W1C and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = registered OR of all STATUS bits across all banks.
- Reset clears everything: OUT, OE, RISE_EN, FALL_EN, STATUS, sync chain, prev, mst_ready, mst_rdata and irq are all 0.
  - A pin held high through reset produces a rise after reset. It latches only if RISE_EN has been written first.
  - srst asserted mid-access: the access is dropped, no write takes effect and ready stays 0. The master must reissue.

## Timing
- Access FSM: IDLE -> (en) ACK -> IDLE.
  - In IDLE with mst_en=1, the access executes at the clock edge. mst_ready=1 and rdata are valid the following cycle (1-cycle latency).
  - ACK lasts exactly one cycle, ready then returns to 0.
  - While in ACK, mst_en is ignored. Back-to-back accesses therefore complete at most every 2 cycles (ready pattern 1,0,1).
- Write effects are visible on gpio_out/gpio_oe in the same cycle mst_ready=1.
- Read data is captured at the execute edge. A read of IN returns the synchroniser value at that edge.
- Pin change to IN: visible after SYNC_STAGES edges.
- Pin change to STATUS: set at edge SYNC_STAGES+1.
- Pin change to irq: asserted at edge SYNC_STAGES+2.
- W1C of the last pending bit: STATUS clears at the execute edge and irq drops one cycle later.

## Test plan
- Reset, then write bank0 OUT=0x09876543 with strb=0xF, and OE=0xFFFFFFFF → gpio_out[31:0]=0x09876543 and gpio_oe[31:0]=all ones at ready. Then write bank1 OUT with strb=0x2 and wdata=0xAABBCCDD → gpio_out[63:32]=0x0000CC00.
- Drive gpio_in[31:0]=0xA5A5A5A5 and wait SYNC_STAGES cycles, then read addr 1 → rdata=0xA5A5A5A5. Read addr 0x9 (bank1 IN) with gpio_in[63:32]=0x5A5A5A5A → rdata=0x5A5A5A5A.
- With OUT=0xF0, write SET=0x0F and then CLR=0x81 → OUT reads back 0x7E. Reads of addr 6 and 7 return 0.
- Write RISE_EN[0]=1 and FALL_EN[1]=1, then toggle pin0 0→1 and pin1 1→0:
  - STATUS=0x3 and irq=1 at edge SYNC_STAGES+2.
  - W1C with 0x1 → STATUS=0x2 and irq stays 1.
  - W1C with 0x2 while a new pin1 falling edge arrives on the same edge → bit1 stays set.
- Access to address 0x1000 (bank out of range), both write and read → ready within 2 cycles, rdata=0, and all registers unchanged.
- Assert srst in the cycle after a write is issued → no register changes, ready=0, and all outputs return to 0. After deassertion, a reissued write completes normally.
